peripheral_bus_arbiter: RTL and testbench

Shares the single 16-bit peripheral bus between two requesters, master 0 and master 1. Typical requesters are the Wishbone slave port and the on-chip core's data port. The block grants the bus round-robin and drives `peripheralEnable`, address and write data toward the per-device address decoders. It waits on the selected device's busy signal and returns read data or a timeout error to the granted requester. It sits between the requester ports and the peripheral decode/mux fabric.

---
 rtl/peripheral_bus_arbiter_if.sv | 50 +++++
 rtl/peripheral_bus_arbiter.sv | 102 ++++++++++
 tb/tb_peripheral_bus_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/peripheral_bus_arbiter_if.sv
// Requester and peripheral-bus signal bundle for peripheral_bus_arbiter.
// The slave modport is the arbiter's view; master is the requester/device side.
interface peripheral_bus_arbiter_if;
    logic        m0_valid;
    logic        m0_we;
    logic [15:0] m0_address;
    logic [3:0]  m0_byteSelect;
    logic [31:0] m0_dataWrite;
    logic        m0_ready;
    logic        m0_error;
    logic [31:0] m0_dataRead;

    logic        m1_valid;
    logic        m1_we;
    logic [15:0] m1_address;
    logic [3:0]  m1_byteSelect;
    logic [31:0] m1_dataWrite;
    logic        m1_ready;
    logic        m1_error;
    logic [31:0] m1_dataRead;

    logic        peripheralEnable;
    logic        peripheralBus_we;
    logic        peripheralBus_oe;
    logic [15:0] peripheralBus_address;
    logic [3:0]  peripheralBus_byteSelect;
    logic [31:0] peripheralBus_dataWrite;
    logic        peripheralBus_busy;
    logic [31:0] peripheralBus_dataRead;

    modport slave (
        input  m0_valid, m0_we, m0_address, m0_byteSelect, m0_dataWrite,
        output m0_ready, m0_error, m0_dataRead,
        input  m1_valid, m1_we, m1_address, m1_byteSelect, m1_dataWrite,
        output m1_ready, m1_error, m1_dataRead,
        output peripheralEnable, peripheralBus_we, peripheralBus_oe,
        output peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
        input  peripheralBus_busy, peripheralBus_dataRead
    );

    modport master (
        output m0_valid, m0_we, m0_address, m0_byteSelect, m0_dataWrite,
        input  m0_ready, m0_error, m0_dataRead,
        output m1_valid, m1_we, m1_address, m1_byteSelect, m1_dataWrite,
        input  m1_ready, m1_error, m1_dataRead,
        input  peripheralEnable, peripheralBus_we, peripheralBus_oe,
        input  peripheralBus_address, peripheralBus_byteSelect, peripheralBus_dataWrite,
        output peripheralBus_busy, peripheralBus_dataRead
    );
endinterface

// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter sharing the 16-bit peripheral bus between two requesters,
// with a busy-cycle timeout that returns error and all-ones read data.
module peripheral_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                     clk,
    input logic                     rst_n,
    peripheral_bus_arbiter_if.slave bus
);
    // One-hot encoding so every strobe decodes from a single state flop.
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ACCESS  = 3'b010,
        RESPOND = 3'b100
    } state_t;

    state_t      r_state, w_next;
    logic        r_grant, r_lastGrant, r_we, r_error;
    logic [7:0]  r_count;
    logic [15:0] r_address;
    logic [3:0]  r_byteSelect;
    logic [31:0] r_dataWrite, r_m0_dataRead, r_m1_dataRead;
    logic        w_req, w_win, w_timeout, w_done;
    logic [31:0] w_rdata;

    assign w_req     = bus.m0_valid | bus.m1_valid;
    assign w_win     = (bus.m0_valid & bus.m1_valid) ? ~r_lastGrant : bus.m1_valid;
    assign w_timeout = bus.peripheralBus_busy && (r_count == 8'(TIMEOUT_CYCLES));
    assign w_done    = ~bus.peripheralBus_busy | w_timeout;

    always_comb begin
        w_rdata = '1;
        if (!bus.peripheralBus_busy)
            w_rdata = r_we ? '0 : bus.peripheralBus_dataRead;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_req)  w_next = ACCESS;
            ACCESS:  if (w_done) w_next = RESPOND;
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.peripheralEnable = r_state == ACCESS;
        bus.peripheralBus_we = (r_state == ACCESS) &  r_we;
        bus.peripheralBus_oe = (r_state == ACCESS) & ~r_we;
        bus.m0_ready         = (r_state == RESPOND) & ~r_grant;
        bus.m1_ready         = (r_state == RESPOND) &  r_grant;
        bus.m0_error         = (r_state == RESPOND) & ~r_grant & r_error;
        bus.m1_error         = (r_state == RESPOND) &  r_grant & r_error;
    end

    assign bus.peripheralBus_address    = r_address;
    assign bus.peripheralBus_byteSelect = r_byteSelect;
    assign bus.peripheralBus_dataWrite  = r_dataWrite;
    assign bus.m0_dataRead              = r_m0_dataRead;
    assign bus.m1_dataRead              = r_m1_dataRead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= 1'b0;
            r_lastGrant   <= 1'b1;
            r_we          <= 1'b0;
            r_error       <= 1'b0;
            r_count       <= '0;
            r_address     <= '0;
            r_byteSelect  <= '0;
            r_dataWrite   <= '0;
            r_m0_dataRead <= '0;
            r_m1_dataRead <= '0;
        end else begin
            if (r_state == IDLE && w_req) begin
                r_grant      <= w_win;
                r_lastGrant  <= w_win;
                r_count      <= '0;
                r_we         <= w_win ? bus.m1_we : bus.m0_we;
                r_address    <= w_win ? bus.m1_address : bus.m0_address;
                r_dataWrite  <= w_win ? bus.m1_dataWrite : bus.m0_dataWrite;
                if (w_win) r_byteSelect <= bus.m1_we ? bus.m1_byteSelect : 4'hF;
                else       r_byteSelect <= bus.m0_we ? bus.m0_byteSelect : 4'hF;
            end
            if (r_state == ACCESS) begin
                if (w_done) begin
                    r_error <= bus.peripheralBus_busy;
                    if (r_grant) r_m1_dataRead <= w_rdata;
                    else         r_m0_dataRead <= w_rdata;
                end else begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Self-checking bench for peripheral_bus_arbiter (TIMEOUT_CYCLES=4): vector table,
// contention, reset-mid-access, with a response scoreboard.
module tb_peripheral_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    peripheral_bus_arbiter_if bus ();
    peripheral_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Device model: busy for the first busy_len ACCESS cycles of a transfer.
    int          acc_idx  = 0;
    int          busy_len = 0;
    logic        rd_auto  = 1'b0;
    logic [31:0] rd_fixed = '0;
    always @(posedge clk) acc_idx <= bus.peripheralEnable ? acc_idx + 1 : 0;
    assign bus.peripheralBus_busy     = acc_idx < busy_len;
    assign bus.peripheralBus_dataRead = rd_auto ? {16'hD0D0, bus.peripheralBus_address} : rd_fixed;

    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        m;
        logic        we;
        logic [15:0] addr;
        logic [3:0]  bs;
        logic [31:0] wd;
        int          nbusy;
        logic [31:0] rd;
        int          drop;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    resp_t sb[$];
    vec_t  vecs[8];
    int    checks = 0;
    int    failures = 0;
    int    en_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(output logic rdy);
        resp_t e;
        @(negedge clk);
        if (bus.peripheralEnable) en_cnt++;
        rdy = bus.m0_ready | bus.m1_ready;
        if (rdy) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual m0=%0b m1=%0b required=none", bus.m0_ready, bus.m1_ready);
            end else begin
                e = sb.pop_front();
                check("ready_owner", {30'b0, bus.m1_ready, bus.m0_ready}, e.m ? 32'd2 : 32'd1);
                check("error", e.m ? bus.m1_error : bus.m0_error, e.err);
                check("dataRead", e.m ? bus.m1_dataRead : bus.m0_dataRead, e.data);
                check("other_error", e.m ? bus.m0_error : bus.m1_error, 0);
            end
        end
    endtask

    task automatic rst_checks(input string tag);
        check({tag, "_strobes"}, {25'b0, bus.peripheralEnable, bus.peripheralBus_we, bus.peripheralBus_oe,
              bus.m0_ready, bus.m1_ready, bus.m0_error, bus.m1_error}, 0);
        check({tag, "_addr"}, {16'b0, bus.peripheralBus_address}, 0);
        check({tag, "_bs"}, {28'b0, bus.peripheralBus_byteSelect}, 0);
        check({tag, "_wd"}, bus.peripheralBus_dataWrite, 0);
        check({tag, "_m0_rd"}, bus.m0_dataRead, 0);
        check({tag, "_m1_rd"}, bus.m1_dataRead, 0);
    endtask

    task automatic drive(input logic m, input logic we, input logic [15:0] a, input logic [3:0] bs, input logic [31:0] wd);
        if (m) begin
            bus.m1_valid = 1'b1; bus.m1_we = we; bus.m1_address = a; bus.m1_byteSelect = bs; bus.m1_dataWrite = wd;
        end else begin
            bus.m0_valid = 1'b1; bus.m0_we = we; bus.m0_address = a; bus.m0_byteSelect = bs; bus.m0_dataWrite = wd;
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic rdy;
        int   lat = -1;
        rd_auto = 1'b0;
        rd_fixed = v.rd;
        busy_len = v.nbusy;
        en_cnt = 0;
        drive(v.m, v.we, v.addr, v.bs, v.wd);
        sb.push_back('{v.m, v.exp_err, v.exp_data});
        for (int c = 1; c <= 300 && lat < 0; c++) begin
            tick(rdy);
            if (bus.peripheralEnable) begin
                check("bus_addr", {16'b0, bus.peripheralBus_address}, {16'b0, v.addr});
                check("bus_we_oe", {30'b0, bus.peripheralBus_we, bus.peripheralBus_oe}, v.we ? 32'd2 : 32'd1);
                check("bus_bs", {28'b0, bus.peripheralBus_byteSelect}, v.we ? {28'b0, v.bs} : 32'hF);
                if (v.we) check("bus_wd", bus.peripheralBus_dataWrite, v.wd);
            end
            if (c == v.drop) begin
                if (v.m) begin
                    bus.m1_valid = 1'b0; bus.m1_address = ~v.addr; bus.m1_we = ~v.we; bus.m1_dataWrite = ~v.wd;
                end else begin
                    bus.m0_valid = 1'b0; bus.m0_address = ~v.addr; bus.m0_we = ~v.we; bus.m0_dataWrite = ~v.wd;
                end
            end
            if (rdy) begin
                lat = c;
                bus.m0_valid = 1'b0;
                bus.m1_valid = 1'b0;
            end
        end
        check("latency", lat, v.exp_lat);
        check("enable_cycles", en_cnt, v.exp_lat - 1);
        tick(rdy);
        busy_len = 0;
    endtask

    task automatic contend(input int n);
        logic rdy;
        int   nr = 0;
        int   c = 0;
        rd_auto = 1'b1;
        busy_len = 0;
        drive(1'b0, 1'b0, 16'h0100, 4'h0, '0);
        drive(1'b1, 1'b0, 16'h0200, 4'h0, '0);
        for (int i = 0; i < n; i++)
            sb.push_back('{i[0], 1'b0, i[0] ? 32'hD0D0_0200 : 32'hD0D0_0100});
        while (nr < n && c < 100) begin
            c++;
            tick(rdy);
            if (rdy) begin
                nr++;
                check("contend_spacing", c, 3 * nr - 1);
            end
        end
        check("contend_count", nr, n);
        bus.m0_valid = 1'b0;
        bus.m1_valid = 1'b0;
        tick(rdy);
        rd_auto = 1'b0;
    endtask

    task automatic reset_dut();
        bus.m0_valid = 1'b0;
        bus.m1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_checks("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic rdy;
        bus.m0_valid = 1'b0; bus.m0_we = 1'b0; bus.m0_address = '0; bus.m0_byteSelect = '0; bus.m0_dataWrite = '0;
        bus.m1_valid = 1'b0; bus.m1_we = 1'b0; bus.m1_address = '0; bus.m1_byteSelect = '0; bus.m1_dataWrite = '0;

        //         m     we    addr      bs    wd            nbusy rd            drop err   exp_data      lat
        vecs[0] = '{1'b0, 1'b0, 16'h1004, 4'h0, 32'h0,        0,  32'hCAFE_0001, 0, 1'b0, 32'hCAFE_0001, 2};
        vecs[1] = '{1'b1, 1'b1, 16'h2010, 4'h3, 32'h1234_5678, 3, 32'hBAD0_BAD0, 0, 1'b0, 32'h0,         5};
        vecs[2] = '{1'b0, 1'b0, 16'h3000, 4'h0, 32'h0,        99, 32'h1111_2222, 0, 1'b1, 32'hFFFF_FFFF, 6};
        vecs[3] = '{1'b1, 1'b0, 16'h3004, 4'h5, 32'h0,        1,  32'hA5A5_5A5A, 0, 1'b0, 32'hA5A5_5A5A, 3};
        vecs[4] = '{1'b0, 1'b1, 16'h3008, 4'hF, 32'h0BAD_F00D, 4, 32'h5555_AAAA, 0, 1'b0, 32'h0,         6};
        vecs[5] = '{1'b0, 1'b1, 16'h5000, 4'hC, 32'hDEAD_BEEF, 2, 32'h0,         1, 1'b0, 32'h0,         4};
        vecs[6] = '{1'b0, 1'b0, 16'h5004, 4'h0, 32'h0,        0,  32'h600D_CAFE, 0, 1'b0, 32'h600D_CAFE, 2};
        vecs[7] = '{1'b1, 1'b0, 16'h6000, 4'h0, 32'h0,        0,  32'h7777_8888, 0, 1'b0, 32'h7777_8888, 2};

        reset_dut();
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        reset_dut();
        contend(4);

        // Abort a stalled transfer with reset: outputs clear at once, no ready follows.
        busy_len = 50;
        rd_fixed = 32'h4444_4444;
        drive(1'b0, 1'b0, 16'h4000, 4'h0, '0);
        repeat (3) tick(rdy);
        check("pre_reset_enable", {31'b0, bus.peripheralEnable}, 1);
        rst_n = 1'b0;
        bus.m0_valid = 1'b0;
        #1;
        rst_checks("midreset");
        repeat (2) tick(rdy);
        rst_n = 1'b1;
        busy_len = 0;
        run_vec(vecs[7]);
        contend(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
